// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package pipe_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MDU_BUSY = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         MUL_CYCLES_DEF = 4;
    localparam int         DIV_CYCLES_DEF = 32;
    localparam int         MDU_CNT_W      = 6;
    localparam int         PERF_CNT_W     = 32;

    // A DEC source operand collides with the EX destination.
    function automatic logic src_hit(input logic       use_i,
                                     input logic [4:0] ra_i,
                                     input logic [4:0] wra_i);
        return use_i && (ra_i == wra_i);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational hazard terms: load-use interlock and MDU result/resource hazard.
module pipeline_ctrl_hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] dec_ra1_i,
    input  logic [4:0] dec_ra2_i,
    input  logic       dec_use1_i,
    input  logic       dec_use2_i,
    input  logic [4:0] ex_wra_i,
    input  logic       ex_reg_we_i,
    input  logic       ex_is_load_i,
    input  logic       dec_mdu_start_i,
    input  logic       dec_mdu_read_i,
    input  logic       mdu_busy_i,
    output logic       lu_o,
    output logic       md_o
);

    // Register 0 is hardwired, so a load targeting it never interlocks.
    always_comb begin
        lu_o = ex_is_load_i && ex_reg_we_i && (ex_wra_i != REG_ZERO) &&
               (src_hit(dec_use1_i, dec_ra1_i, ex_wra_i) ||
                src_hit(dec_use2_i, dec_ra2_i, ex_wra_i));
        md_o = mdu_busy_i && (dec_mdu_read_i || dec_mdu_start_i);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline with MDU tracking
// and stall/flush performance counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no multiply/divide in flight; a start may be accepted
// MDU_BUSY | MDU running; count_q holds remaining busy cycles (N..1)
//
// MUL_CYCLES and DIV_CYCLES must be within 1..63 to fit the 6-bit count.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  i_dec_ra1,
    input  logic [4:0]  i_dec_ra2,
    input  logic        i_dec_use1,
    input  logic        i_dec_use2,
    input  logic [4:0]  i_ex_wra,
    input  logic        i_ex_regWe,
    input  logic        i_ex_isLoad,
    input  logic        i_dec_mdu_start,
    input  logic        i_dec_mdu_isDiv,
    input  logic        i_dec_mdu_read,
    input  logic        i_ex_brTaken,
    input  logic        i_mem_busy,
    output logic        o_stall_if,
    output logic        o_stall_dec,
    output logic        o_stall_ex,
    output logic        o_stall_mem,
    output logic        o_flush_dec,
    output logic        o_flush_ex,
    output logic        o_mdu_go,
    output logic        o_mdu_busy,
    output logic        o_mdu_done,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt
);

    localparam logic [MDU_CNT_W-1:0] MUL_LOAD = MDU_CNT_W'(MUL_CYCLES);
    localparam logic [MDU_CNT_W-1:0] DIV_LOAD = MDU_CNT_W'(DIV_CYCLES);

    if (MUL_CYCLES < 1 || MUL_CYCLES > 63 || DIV_CYCLES < 1 || DIV_CYCLES > 63) begin : g_bad_cycles
        $error("pipeline_ctrl: MUL_CYCLES/DIV_CYCLES must be within 1..63");
    end

    state_e                 state_q, state_d;
    logic [MDU_CNT_W-1:0]   count_q, count_d;
    logic                   done_q, done_d;
    logic [PERF_CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic                   lu, md;

    pipeline_ctrl_hazard_detect u_hazard (
        .dec_ra1_i       (i_dec_ra1),
        .dec_ra2_i       (i_dec_ra2),
        .dec_use1_i      (i_dec_use1),
        .dec_use2_i      (i_dec_use2),
        .ex_wra_i        (i_ex_wra),
        .ex_reg_we_i     (i_ex_regWe),
        .ex_is_load_i    (i_ex_isLoad),
        .dec_mdu_start_i (i_dec_mdu_start),
        .dec_mdu_read_i  (i_dec_mdu_read),
        .mdu_busy_i      (o_mdu_busy),
        .lu_o            (lu),
        .md_o            (md)
    );

    assign o_mdu_busy  = (state_q == MDU_BUSY);
    assign o_mdu_done  = done_q;
    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

    // Prioritised stall/flush decode; a mem freeze outranks a branch flush,
    // and a taken branch discards whatever hazard the wrong-path DEC op had.
    always_comb begin
        o_stall_if  = 1'b0;
        o_stall_dec = 1'b0;
        o_stall_ex  = 1'b0;
        o_stall_mem = 1'b0;
        o_flush_dec = 1'b0;
        o_flush_ex  = 1'b0;
        if (!rstn) begin
            o_stall_if = 1'b0;
        end else if (i_mem_busy) begin
            o_stall_if  = 1'b1;
            o_stall_dec = 1'b1;
            o_stall_ex  = 1'b1;
            o_stall_mem = 1'b1;
        end else if (i_ex_brTaken) begin
            o_flush_dec = 1'b1;
        end else if (lu || md) begin
            o_stall_if  = 1'b1;
            o_stall_dec = 1'b1;
            o_flush_ex  = 1'b1;
        end
        o_mdu_go = rstn && i_dec_mdu_start && !o_mdu_busy && !i_mem_busy &&
                   !i_ex_brTaken && !lu;
    end

    // MDU FSM next state; the count keeps running through mem freezes.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (o_mdu_go) begin
                    state_d = MDU_BUSY;
                    count_d = i_dec_mdu_isDiv ? DIV_LOAD : MUL_LOAD;
                end
            end
            MDU_BUSY: begin
                count_d = count_q - MDU_CNT_W'(1);
                if (count_q == MDU_CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // MDU state, remaining-cycle count and registered done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Performance counters, free-running and wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (o_stall_dec) begin
                stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
            end
            if (o_flush_dec || o_flush_ex) begin
                flush_cnt_q <= flush_cnt_q + PERF_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a driver issues directed and random
// cycles, a cycle-indexed reference model queues the expected response, and
// a monitor compares at the falling edge.
module tb_pipeline_ctrl;

    localparam int MULN = 4;
    localparam int DIVN = 32;

    typedef struct packed {
        logic [4:0] ra1, ra2, wra;
        logic use1, use2, regWe, isLoad;
        logic start, isDiv, read, br, mem;
    } stim_t;

    typedef struct {
        int          cyc;
        logic [8:0]  ctl;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [4:0] i_dec_ra1 = '0, i_dec_ra2 = '0, i_ex_wra = '0;
    logic i_dec_use1 = 0, i_dec_use2 = 0, i_ex_regWe = 0, i_ex_isLoad = 0;
    logic i_dec_mdu_start = 0, i_dec_mdu_isDiv = 0, i_dec_mdu_read = 0;
    logic i_ex_brTaken = 0, i_mem_busy = 0;
    logic o_stall_if, o_stall_dec, o_stall_ex, o_stall_mem;
    logic o_flush_dec, o_flush_ex, o_mdu_go, o_mdu_busy, o_mdu_done;
    logic [31:0] o_stall_cnt, o_flush_cnt;

    pipeline_ctrl #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk(clk), .rstn(rstn),
        .i_dec_ra1(i_dec_ra1), .i_dec_ra2(i_dec_ra2),
        .i_dec_use1(i_dec_use1), .i_dec_use2(i_dec_use2),
        .i_ex_wra(i_ex_wra), .i_ex_regWe(i_ex_regWe), .i_ex_isLoad(i_ex_isLoad),
        .i_dec_mdu_start(i_dec_mdu_start), .i_dec_mdu_isDiv(i_dec_mdu_isDiv),
        .i_dec_mdu_read(i_dec_mdu_read), .i_ex_brTaken(i_ex_brTaken),
        .i_mem_busy(i_mem_busy),
        .o_stall_if(o_stall_if), .o_stall_dec(o_stall_dec),
        .o_stall_ex(o_stall_ex), .o_stall_mem(o_stall_mem),
        .o_flush_dec(o_flush_dec), .o_flush_ex(o_flush_ex),
        .o_mdu_go(o_mdu_go), .o_mdu_busy(o_mdu_busy), .o_mdu_done(o_mdu_done),
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    // Reference model: MDU occupancy as cycle windows, counters as totals.
    int cyc, busy_from, busy_to, done_at;
    logic [31:0] m_stall, m_flush;

    task automatic model_reset();
        cyc = 0; busy_from = 1; busy_to = 0; done_at = -1;
        m_stall = '0; m_flush = '0;
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        logic busy, done, lu, md, go;
        logic sif, sdec, sex, smem, fdec, fex;
        @(posedge clk);
        #1;
        i_dec_ra1 = s.ra1; i_dec_ra2 = s.ra2; i_ex_wra = s.wra;
        i_dec_use1 = s.use1; i_dec_use2 = s.use2;
        i_ex_regWe = s.regWe; i_ex_isLoad = s.isLoad;
        i_dec_mdu_start = s.start; i_dec_mdu_isDiv = s.isDiv;
        i_dec_mdu_read = s.read; i_ex_brTaken = s.br; i_mem_busy = s.mem;
        cyc++;
        busy = (cyc >= busy_from) && (cyc <= busy_to);
        done = (cyc == done_at);
        lu = s.isLoad && s.regWe && (s.wra != 0) &&
             ((s.use1 && s.ra1 == s.wra) || (s.use2 && s.ra2 == s.wra));
        md = busy && (s.read || s.start);
        {sif, sdec, sex, smem, fdec, fex} = '0;
        if (s.mem)          {sif, sdec, sex, smem} = 4'b1111;
        else if (s.br)      fdec = 1'b1;
        else if (lu || md)  {sif, sdec, fex} = 3'b111;
        go = s.start && !busy && !s.mem && !s.br && !lu;
        e.cyc = cyc;
        e.ctl = {sif, sdec, sex, smem, fdec, fex, go, busy, done};
        e.sc  = m_stall;
        e.fc  = m_flush;
        exp_q.push_back(e);
        if (sdec) m_stall = m_stall + 1;
        if (fdec || fex) m_flush = m_flush + 1;
        if (go) begin
            int n;
            n = s.isDiv ? DIVN : MULN;
            busy_from = cyc + 1;
            busy_to   = cyc + n;
            done_at   = cyc + n + 1;
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd8;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.ra1 = pick_reg(); s.ra2 = pick_reg(); s.wra = pick_reg();
        s.use1 = 1'($urandom_range(0, 1));
        s.use2 = 1'($urandom_range(0, 1));
        s.regWe = ($urandom_range(0, 9) < 8);
        s.isLoad = 1'($urandom_range(0, 1));
        s.start = ($urandom_range(0, 9) < 2);
        s.isDiv = ($urandom_range(0, 9) < 3);
        s.read = ($urandom_range(0, 9) < 2);
        s.br = ($urandom_range(0, 9) < 1);
        s.mem = ($urandom_range(0, 19) < 3);
        return s;
    endfunction

    // Monitor: every evaluated cycle yields one response to score.
    initial begin
        exp_t e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {o_stall_if, o_stall_dec, o_stall_ex, o_stall_mem,
                       o_flush_dec, o_flush_ex, o_mdu_go, o_mdu_busy, o_mdu_done};
                n_checks++;
                if (act !== e.ctl) begin
                    n_fail++;
                    $display("FAIL ctl cyc=%0d got=%b expected=%b (if,dec,ex,mem,fdec,fex,go,busy,done)",
                             e.cyc, act, e.ctl);
                end
                n_checks++;
                if (o_stall_cnt !== e.sc || o_flush_cnt !== e.fc) begin
                    n_fail++;
                    $display("FAIL perf_cnt cyc=%0d got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                             e.cyc, o_stall_cnt, o_flush_cnt, e.sc, e.fc);
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        n_checks++;
        if ({o_stall_if, o_stall_dec, o_stall_ex, o_stall_mem, o_flush_dec,
             o_flush_ex, o_mdu_go, o_mdu_busy, o_mdu_done} !== 9'b0) begin
            n_fail++;
            $display("FAIL %s_outputs got=%b expected=0", tag,
                     {o_stall_if, o_stall_dec, o_stall_ex, o_stall_mem, o_flush_dec,
                      o_flush_ex, o_mdu_go, o_mdu_busy, o_mdu_done});
        end
        n_checks++;
        if (o_stall_cnt !== 32'd0 || o_flush_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL %s_counters got stall=%0d flush=%0d expected 0/0", tag,
                     o_stall_cnt, o_flush_cnt);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 5) begin
            @(posedge clk);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
    endtask

    initial begin
        stim_t s;
        model_reset();
        // Outputs must stay low while reset is held, even with a mem freeze request.
        i_mem_busy = 1'b1; i_dec_mdu_start = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_reset_state("reset_hold");
        i_mem_busy = 1'b0; i_dec_mdu_start = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // Load-use on ra1 = 8, then idle so the counter update is observed.
        s = idle_stim(); s.isLoad = 1; s.regWe = 1; s.wra = 5'd8; s.use1 = 1; s.ra1 = 5'd8;
        drive(s);
        drive(idle_stim());
        // Load to r0 with ra1 = 0: no hazard.
        s = idle_stim(); s.isLoad = 1; s.regWe = 1; s.wra = 5'd0; s.use1 = 1; s.ra1 = 5'd0;
        drive(s);
        // Branch taken alongside a load-use on ra2.
        s = idle_stim(); s.isLoad = 1; s.regWe = 1; s.wra = 5'd5; s.use2 = 1; s.ra2 = 5'd5; s.br = 1;
        drive(s);
        drive(idle_stim());

        // Divide followed by a dependent mfhi held in DEC.
        s = idle_stim(); s.start = 1; s.isDiv = 1;
        drive(s);
        s = idle_stim(); s.read = 1;
        repeat (DIVN + 1) drive(s);
        drive(idle_stim());

        // Multiply with a 3-cycle mem freeze inside the busy window.
        s = idle_stim(); s.start = 1;
        drive(s);
        s = idle_stim(); s.mem = 1;
        repeat (3) drive(s);
        repeat (4) drive(idle_stim());

        // Back-to-back starts: second waits until busy drops.
        s = idle_stim(); s.start = 1;
        repeat (MULN + 3) drive(s);
        repeat (MULN + 2) drive(idle_stim());

        for (int i = 0; i < 3000; i++) drive(rand_stim());

        // Let any MDU op finish, start a divide, then reset mid-op.
        repeat (DIVN + 2) drive(idle_stim());
        s = idle_stim(); s.start = 1; s.isDiv = 1;
        drive(s);
        repeat (5) drive(idle_stim());
        drain();
        @(posedge clk);
        #7;
        i_mem_busy = 1'b1;
        rstn = 1'b0;
        #1;
        check_reset_state("reset_midop");
        @(posedge clk);
        i_mem_busy = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        repeat (DIVN + 5) drive(idle_stim());
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
